// File: rtl/poly_seq_ctrl.sv
// ---------------------------------------------------------------------------
// poly_seq_ctrl
//
// Sequencer for the polynomial datapath (operand mux A/B/C, registers
// R0/R1/R2, sum/multiply ALU). Evaluates
//     quadratic: y = ((A*x) + B)*x + C      (Horner's rule)
//     linear   : y = B*x + C
// and leaves y in R1 (datapath output Pronto) when done pulses.
//
// Parameters
//   MUL_CYC  cycles each multiply state is held (ALU settle time), 1..15
//   ADD_CYC  cycles each add state is held, 1..15
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   RST      asynchronous active-low reset
//   start    evaluation request, sampled only while idle
//   linear   0 = quadratic, 1 = linear; captured when start is accepted
//   busy     high from the cycle after start is accepted through DONE
//   done     one-cycle pulse, result valid in R1 during and after it
//   LX       load R0 <= x
//   LH       load R1 <= ALU out
//   LS       load R2 <= ALU out (snapshot build only, otherwise 0)
//   M0       operand mux: 0 = idle, 1 = A, 2 = B, 3 = C
//   M1       ALU port 1:  0 = M0 out, 1 = R0, 2 = R1, 3 = R2
//   M2       ALU port 2:  0 = R0, 1 = M0 out, 2 = R1, 3 = R2
//   H        ALU op: 1 = multiply, 0 = add
//   cyc_cnt  busy-cycle counter, saturating at 255 (snapshot build only)
//
// Build option
//   POLY_SEQ_SNAPSHOT_EN  when defined, the DONE cycle also loads
//                         R2 <= y*x, and the cyc_cnt port is added.
// ---------------------------------------------------------------------------
module poly_seq_ctrl #(
    parameter int MUL_CYC = 2,
    parameter int ADD_CYC = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       linear,
    output logic       busy,
    output logic       done,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H
`ifdef POLY_SEQ_SNAPSHOT_EN
    ,
    output logic [7:0] cyc_cnt
`endif
);

    // State encoding
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOADX = 3'd1;
    localparam logic [2:0] MUL1  = 3'd2;
    localparam logic [2:0] ADD1  = 3'd3;
    localparam logic [2:0] MUL2  = 3'd4;
    localparam logic [2:0] ADD2  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    // Operand mux (M0) codes
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_A    = 2'd1;
    localparam logic [1:0] OP_B    = 2'd2;
    localparam logic [1:0] OP_C    = 2'd3;

    // ALU port 1 (M1) codes
    localparam logic [1:0] P1_MUX = 2'd0;
    localparam logic [1:0] P1_R1  = 2'd2;

    // ALU port 2 (M2) codes
    localparam logic [1:0] P2_R0  = 2'd0;
    localparam logic [1:0] P2_MUX = 2'd1;

    // Final wait-counter value of each hold; the counter starts at 0 on entry.
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYC - 1);
    localparam logic [3:0] ADD_LAST = 4'(ADD_CYC - 1);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic [3:0] waitCnt;
    logic       linearLatch;
    logic       isMulState;
    logic       isOpState;
    logic       holdLast;

    // -----------------------------------------------------------------------
    // Hold bookkeeping: an op state ends when the counter reaches its
    // last value; that is also the only cycle R1 is allowed to load.
    // -----------------------------------------------------------------------
    always_comb begin
        isMulState = (state == MUL1) || (state == MUL2);
        isOpState  = isMulState || (state == ADD1) || (state == ADD2);
        holdLast   = isOpState &&
                     (waitCnt == (isMulState ? MUL_LAST : ADD_LAST));
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns stateNext; no latch.
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = LOADX;
            LOADX:   stateNext = MUL1;
            MUL1:    if (holdLast) stateNext = linearLatch ? ADD2 : ADD1;
            ADD1:    if (holdLast) stateNext = MUL2;
            MUL2:    if (holdLast) stateNext = ADD2;
            ADD2:    if (holdLast) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register, wait counter and mode latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        // NOTE: only control state is reset here; the datapath registers
        // it steers live elsewhere and are always written before use.
        if (!RST) begin
            state       <= IDLE;
            waitCnt     <= '0;
            linearLatch <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values.
            state <= stateNext;

            // Cleared on every state change, so each op state starts its
            // hold at 0; outside op states it simply stays cleared.
            if ((stateNext != state) || !isOpState) begin
                waitCnt <= '0;
            end else begin
                waitCnt <= waitCnt + 4'd1;
            end

            // Mode is frozen for the whole evaluation; later changes on
            // linear are ignored until the next accepted start.
            if ((state == IDLE) && start) begin
                linearLatch <= linear;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Moore output decode (state + wait counter only, never start)
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        LX   = 1'b0;
        LH   = 1'b0;
        LS   = 1'b0;
        M0   = OP_NONE;
        M1   = P1_MUX;
        M2   = P2_R0;
        H    = 1'b0;
        case (state)
            LOADX: begin
                busy = 1'b1;
                LX   = 1'b1;
            end
            MUL1: begin
                // R1 <= (A or B) * x
                busy = 1'b1;
                H    = 1'b1;
                M0   = linearLatch ? OP_B : OP_A;
                M1   = P1_MUX;
                M2   = P2_R0;
                LH   = holdLast;
            end
            ADD1: begin
                // R1 <= R1 + B
                busy = 1'b1;
                M0   = OP_B;
                M1   = P1_R1;
                M2   = P2_MUX;
                LH   = holdLast;
            end
            MUL2: begin
                // R1 <= R1 * x
                busy = 1'b1;
                H    = 1'b1;
                M0   = OP_NONE;
                M1   = P1_R1;
                M2   = P2_R0;
                LH   = holdLast;
            end
            ADD2: begin
                // R1 <= R1 + C
                busy = 1'b1;
                M0   = OP_C;
                M1   = P1_R1;
                M2   = P2_MUX;
                LH   = holdLast;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef POLY_SEQ_SNAPSHOT_EN
                // R2 <= y * x while y is already settled in R1
                LS   = 1'b1;
                H    = 1'b1;
                M0   = OP_NONE;
                M1   = P1_R1;
                M2   = P2_R0;
`endif
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef POLY_SEQ_SNAPSHOT_EN
    // -----------------------------------------------------------------------
    // Busy-cycle counter: restarts on an accepted start, counts every busy
    // cycle, sticks at 255, and keeps the last count while idle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cyc_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cyc_cnt <= '0;
        end else if (busy && (cyc_cnt != 8'hFF)) begin
            cyc_cnt <= cyc_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_poly_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_poly_seq_ctrl
//
// Two controllers run side by side on shared stimulus: one with default
// hold times (MUL_CYC=2, ADD_CYC=1) and one with MUL_CYC=3, ADD_CYC=2.
// Each drives its own behavioural datapath. A reference model derives the
// expected control outputs from the cycle offset since start, and a
// scoreboard queue carries the expected y and done cycle of each accepted
// evaluation until the controller signals done.
// ---------------------------------------------------------------------------
module tb_poly_seq_ctrl;

    localparam int FAST_MUL = 2;
    localparam int FAST_ADD = 1;
    localparam int SLOW_MUL = 3;
    localparam int SLOW_ADD = 2;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       lx;
        logic       lh;
        logic       ls;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
    } ctrlVec_t;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
        int          doneCyc;
    } sbEntry_t;

    logic clk    = 1'b0;
    logic RST    = 1'b0;
    logic start  = 1'b0;
    logic linear = 1'b0;

    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic [15:0] opC = '0;
    logic [15:0] xIn = '0;

    logic       fBusy, fDone, fLX, fLH, fLS, fH;
    logic [1:0] fM0, fM1, fM2;
    logic       sBusy, sDone, sLX, sLH, sLS, sH;
    logic [1:0] sM0, sM1, sM2;
`ifdef POLY_SEQ_SNAPSHOT_EN
    logic [7:0] fCyc, sCyc;
`endif

    ctrlVec_t fObs, sObs;
    assign fObs = {fBusy, fDone, fLX, fLH, fLS, fM0, fM1, fM2, fH};
    assign sObs = {sBusy, sDone, sLX, sLH, sLS, sM0, sM1, sM2, sH};

    logic [15:0] fR0 = '0, fR1 = '0, fR2 = '0;
    logic [15:0] sR0 = '0, sR1 = '0, sR2 = '0;

    int nChecks = 0;
    int nErrors = 0;
    int tbCyc   = 0;

    int   expLeft  [2];
    int   curStart [2];
    logic curLin   [2];
    sbEntry_t fq[$];
    sbEntry_t sq[$];

    int winLo    = -1;
    int winHi    = -1;
    int winDones = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tbCyc <= tbCyc + 1;

    poly_seq_ctrl #(.MUL_CYC(FAST_MUL), .ADD_CYC(FAST_ADD)) dut (
        .clk(clk), .RST(RST), .start(start), .linear(linear),
        .busy(fBusy), .done(fDone), .LX(fLX), .LH(fLH), .LS(fLS),
        .M0(fM0), .M1(fM1), .M2(fM2), .H(fH)
`ifdef POLY_SEQ_SNAPSHOT_EN
        , .cyc_cnt(fCyc)
`endif
    );

    poly_seq_ctrl #(.MUL_CYC(SLOW_MUL), .ADD_CYC(SLOW_ADD)) dutSlow (
        .clk(clk), .RST(RST), .start(start), .linear(linear),
        .busy(sBusy), .done(sDone), .LX(sLX), .LH(sLH), .LS(sLS),
        .M0(sM0), .M1(sM1), .M2(sM2), .H(sH)
`ifdef POLY_SEQ_SNAPSHOT_EN
        , .cyc_cnt(sCyc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, tbCyc);
        end
    endtask

    function automatic int latency(input logic lin, input int mc, input int ac);
        return lin ? (2 + mc + ac) : (2 + 2 * mc + 2 * ac);
    endfunction

    function automatic logic [15:0] expY(input logic lin, input logic [15:0] a, b, c, x);
        return lin ? 16'(b * x + c) : 16'(a * x * x + b * x + c);
    endfunction

    // Behavioural ALU + operand mux
    function automatic logic [15:0] aluOut(input logic [1:0] m0, m1, m2, input logic h,
                                           input logic [15:0] r0, r1, r2, a, b, c);
        logic [15:0] mux, p1, p2;
        case (m0)
            2'd1:    mux = a;
            2'd2:    mux = b;
            2'd3:    mux = c;
            default: mux = '0;
        endcase
        case (m1)
            2'd0:    p1 = mux;
            2'd1:    p1 = r0;
            2'd2:    p1 = r1;
            default: p1 = r2;
        endcase
        case (m2)
            2'd0:    p2 = r0;
            2'd1:    p2 = mux;
            2'd2:    p2 = r1;
            default: p2 = r2;
        endcase
        return h ? 16'(p1 * p2) : 16'(p1 + p2);
    endfunction

    // Expected outputs k cycles after the accepting edge (k=1 is LOADX).
    function automatic ctrlVec_t expCtrl(input int k, input logic lin, input int mc, input int ac);
        ctrlVec_t e;
        int t, len, ph, nPh, lat;
        e   = '0;
        lat = latency(lin, mc, ac);
        if (k < 1 || k > lat) return e;
        e.busy = 1'b1;
        if (k == 1) begin
            e.lx = 1'b1;
            return e;
        end
        if (k == lat) begin
            e.done = 1'b1;
`ifdef POLY_SEQ_SNAPSHOT_EN
            e.ls = 1'b1;
            e.m1 = 2'd2;
            e.h  = 1'b1;
`endif
            return e;
        end
        t   = k - 2;
        nPh = lin ? 2 : 4;
        for (int p = 0; p < nPh; p++) begin
            ph  = lin ? ((p == 0) ? 0 : 3) : p;
            len = (ph == 0 || ph == 2) ? mc : ac;
            if (t >= 0 && t < len) begin
                e.lh = (t == len - 1);
                case (ph)
                    0: begin e.h = 1'b1; e.m0 = lin ? 2'd2 : 2'd1; end
                    1: begin e.m0 = 2'd2; e.m1 = 2'd2; e.m2 = 2'd1; end
                    2: begin e.h = 1'b1; e.m1 = 2'd2; end
                    default: begin e.m0 = 2'd3; e.m1 = 2'd2; e.m2 = 2'd1; end
                endcase
            end
            t = t - len;
        end
        return e;
    endfunction

    // Datapath models, one per controller
    always @(posedge clk) begin
        if (fLX) fR0 <= xIn;
        if (fLH) fR1 <= aluOut(fM0, fM1, fM2, fH, fR0, fR1, fR2, opA, opB, opC);
        if (fLS) fR2 <= aluOut(fM0, fM1, fM2, fH, fR0, fR1, fR2, opA, opB, opC);
        if (sLX) sR0 <= xIn;
        if (sLH) sR1 <= aluOut(sM0, sM1, sM2, sH, sR0, sR1, sR2, opA, opB, opC);
        if (sLS) sR2 <= aluOut(sM0, sM1, sM2, sH, sR0, sR1, sR2, opA, opB, opC);
    end

    // Reference model: acceptance, busy window, scoreboard push
    initial begin : refModel
        expLeft[0] = 0;
        expLeft[1] = 0;
        forever begin
            @(posedge clk or negedge RST);
            if (!RST) begin
                expLeft[0] = 0;
                expLeft[1] = 0;
                fq.delete();
                sq.delete();
            end else begin
                if (expLeft[0] == 0) begin
                    if (start) begin
                        expLeft[0]  = latency(linear, FAST_MUL, FAST_ADD);
                        curStart[0] = tbCyc;
                        curLin[0]   = linear;
                        fq.push_back(sbEntry_t'({expY(linear, opA, opB, opC, xIn), xIn, tbCyc + expLeft[0]}));
                    end
                end else begin
                    expLeft[0] = expLeft[0] - 1;
                end
                if (expLeft[1] == 0) begin
                    if (start) begin
                        expLeft[1]  = latency(linear, SLOW_MUL, SLOW_ADD);
                        curStart[1] = tbCyc;
                        curLin[1]   = linear;
                        sq.push_back(sbEntry_t'({expY(linear, opA, opB, opC, xIn), xIn, tbCyc + expLeft[1]}));
                    end
                end else begin
                    expLeft[1] = expLeft[1] - 1;
                end
            end
        end
    end

    // Monitor: sampled on the falling edge
    initial begin : monitor
        ctrlVec_t expv;
        sbEntry_t e;
`ifdef POLY_SEQ_SNAPSHOT_EN
        logic        fPend = 1'b0, sPend = 1'b0;
        logic [15:0] fPendR2 = '0, sPendR2 = '0;
        int          fPendCnt = 0, sPendCnt = 0;
`endif
        forever begin
            @(negedge clk);
            expv = (expLeft[0] != 0) ? expCtrl(tbCyc - curStart[0], curLin[0], FAST_MUL, FAST_ADD) : '0;
            check("ctrl_fast", 32'(fObs), 32'(expv));
            expv = (expLeft[1] != 0) ? expCtrl(tbCyc - curStart[1], curLin[1], SLOW_MUL, SLOW_ADD) : '0;
            check("ctrl_slow", 32'(sObs), 32'(expv));

            if (fDone && tbCyc >= winLo && tbCyc <= winHi) winDones++;

`ifdef POLY_SEQ_SNAPSHOT_EN
            if (fPend) begin
                check("r2_fast", 32'(fR2), 32'(fPendR2));
                check("cyc_cnt_fast", 32'(fCyc), fPendCnt);
                fPend = 1'b0;
            end
            if (sPend) begin
                check("r2_slow", 32'(sR2), 32'(sPendR2));
                check("cyc_cnt_slow", 32'(sCyc), sPendCnt);
                sPend = 1'b0;
            end
`endif
            if (fDone) begin
                if (fq.size() == 0) begin
                    check("sb_fast_unexpected_done", 32'(fq.size()), 1);
                end else begin
                    e = fq.pop_front();
                    check("r1_fast", 32'(fR1), 32'(e.y));
                    check("done_cyc_fast", tbCyc, e.doneCyc);
`ifdef POLY_SEQ_SNAPSHOT_EN
                    fPend    = 1'b1;
                    fPendR2  = 16'(e.y * e.x);
                    fPendCnt = latency(curLin[0], FAST_MUL, FAST_ADD);
                    if (fPendCnt > 255) fPendCnt = 255;
`endif
                end
            end
            if (sDone) begin
                if (sq.size() == 0) begin
                    check("sb_slow_unexpected_done", 32'(sq.size()), 1);
                end else begin
                    e = sq.pop_front();
                    check("r1_slow", 32'(sR1), 32'(e.y));
                    check("done_cyc_slow", tbCyc, e.doneCyc);
`ifdef POLY_SEQ_SNAPSHOT_EN
                    sPend    = 1'b1;
                    sPendR2  = 16'(e.y * e.x);
                    sPendCnt = latency(curLin[1], SLOW_MUL, SLOW_ADD);
                    if (sPendCnt > 255) sPendCnt = 255;
`endif
                end
            end
        end
    end

    // Stimulus changes 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitIdle();
        int budget;
        budget = 200;
        while ((expLeft[0] != 0 || expLeft[1] != 0) && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();
    endtask

    task automatic setOps(input logic [15:0] a, b, c, x, input logic lin);
        opA    = a;
        opB    = b;
        opC    = c;
        xIn    = x;
        linear = lin;
    endtask

    task automatic runEval(input logic [15:0] a, b, c, x, input logic lin);
        setOps(a, b, c, x, lin);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitIdle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin : stimulus
        repeat (3) tick();
        check("reset_fast", 32'(fObs), 0);
        check("reset_slow", 32'(sObs), 0);
        RST = 1'b1;
        tick();

        // Main function, both modes, boundary operands
        runEval(16'd2, 16'd3, 16'd5, 16'd4, 1'b0);          // 49
        runEval(16'd9, 16'd7, 16'd2, 16'd10, 1'b1);         // 72
        runEval(16'd1, 16'd0, 16'd0, 16'd3, 1'b0);          // 9, snapshot 27
        runEval(16'hFFFF, 16'd2, 16'd1, 16'd300, 1'b0);     // wraps
        runEval(16'd5, 16'd6, 16'd7, 16'd0, 1'b0);          // x = 0
        runEval(16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1); // linear wrap

        // start pulses and linear changes while busy are ignored
        setOps(16'd3, 16'd1, 16'd4, 16'd6, 1'b0);
        start = 1'b1;
        tick();
        start  = 1'b0;
        linear = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start  = 1'b0;
        linear = 1'b0;
        waitIdle();

        // start held high for 20 cycles: two dones inside the window
        setOps(16'd2, 16'd3, 16'd5, 16'd4, 1'b0);
        start = 1'b1;
        winLo = tbCyc;
        winHi = tbCyc + 19;
        repeat (20) tick();
        start = 1'b0;
        waitIdle();
        check("handshake_dones", winDones, 2);

        // Asynchronous reset in the middle of MUL2
        setOps(16'd2, 16'd3, 16'd5, 16'd4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #1 RST = 1'b0;
        #1;
        check("rst_async_fast", 32'(fObs), 0);
        check("rst_async_slow", 32'(sObs), 0);
        tick();
        RST = 1'b1;
        tick();
        runEval(16'd2, 16'd3, 16'd5, 16'd4, 1'b0);

        check("sb_fast_drained", fq.size(), 0);
        check("sb_slow_drained", sq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
